mul_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO result registers for the MIPS-style datapath. It executes MULT/MULTU/DIV/DIVU over multiple cycles with a start/busy/done handshake, and services MFHI/MFLO/MTHI/MTLO. It sits beside the single-cycle ALU in EX. The ALU control decodes R-type `function_field` values 0x10–0x1B to this unit instead of the ALU, and the hazard logic stalls on `busy`.

---
 rtl/mul_div_unit.sv | 147 ++++++++++++++
 tb/tb_mul_div_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Three-state FSM; one shift-add or restoring-divide step per RUN cycle.
module mul_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        function_field,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t              state, state_next;
  logic                busy_next, done_next;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   acc_hi, acc_lo, opnd, a_raw;
  logic                is_div, neg_lo, neg_hi;

  logic                iter_op, signed_op, accept, sa, sb;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W:0]     mul_sum, shifted;
  logic [DATA_W-1:0]   diff;
  logic                fits;
  logic [2*DATA_W-1:0] prod, prod_fix;

  always_comb begin
    iter_op   = (function_field == F_MULT) || (function_field == F_MULTU) ||
                (function_field == F_DIV)  || (function_field == F_DIVU);
    signed_op = (function_field == F_MULT) || (function_field == F_DIV);
    accept    = (state == IDLE) && start && iter_op;
    sa        = signed_op & operand_a[DATA_W-1];
    sb        = signed_op & operand_b[DATA_W-1];
    mag_a     = sa ? -operand_a : operand_a;
    mag_b     = sb ? -operand_b : operand_b;
    // acc_hi:acc_lo is the product register for multiply and remainder:dividend for divide
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted   = {acc_hi, acc_lo[DATA_W-1]};
    fits      = shifted >= {1'b0, opnd};
    diff      = shifted[DATA_W-1:0] - opnd;
    prod      = {acc_hi, acc_lo};
    prod_fix  = neg_lo ? -prod : prod;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (cnt == CNT_W'(DATA_W - 1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && function_field == F_MTHI) hi <= operand_a;
          if (start && function_field == F_MTLO) lo <= operand_a;
          if (accept) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= mag_a;
            opnd   <= mag_b;
            a_raw  <= operand_a;
            is_div <= (function_field == F_DIV) || (function_field == F_DIVU);
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc_hi <= fits ? diff : shifted[DATA_W-1:0];
            acc_lo <= {acc_lo[DATA_W-2:0], fits};
          end else begin
            acc_hi <= mul_sum[DATA_W:1];
            acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
          end
        end
        FINISH: begin
          if (!is_div) begin
            hi <= prod_fix[2*DATA_W-1:DATA_W];
            lo <= prod_fix[DATA_W-1:0];
          end else if (opnd == '0) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= neg_hi ? -acc_hi : acc_hi;
            lo <= neg_lo ? -acc_lo : acc_lo;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (function_field == F_MFHI) rd_data = hi;
    else if (function_field == F_MFLO) rd_data = lo;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed-vector bench for mul_div_unit
module tb_mul_div_unit;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  function_field = 6'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo, rd_data;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .function_field(function_field),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge of the done cycle (edges = -1 on timeout).
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int bcyc);
    function_field = f;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    bcyc = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (busy) bcyc++;
      if (edges > 100) begin
        edges = -1;
        break;
      end
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags busy/done=%b expected 00", {busy, done});
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_hilo hi=%h lo=%h expected 0/0", hi, lo);
    end
    rst = 1'b0;
  endtask

  task automatic test_multu_max;
    int e, b;
    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, e, b);
    checks++;
    if (e !== 34) begin errors++; $display("FAIL multu_latency edges=%0d expected 34", e); end
    checks++;
    if (b !== 33) begin errors++; $display("FAIL multu_busy cycles=%0d expected 33", b); end
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++; $display("FAIL multu_result hi=%h lo=%h expected fffffffe/00000001", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_width done=%b expected 0", done); end
  endtask

  task automatic test_mult_signed;
    int e, b;
    run_op(F_MULT, 32'hFFFFFFFD, 32'd7, e, b);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL mult_result hi=%h lo=%h expected ffffffff/ffffffeb", hi, lo);
    end
    @(negedge clk);
    function_field = F_MFHI;
    #1;
    checks++;
    if (rd_data !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL mfhi rd_data=%h expected ffffffff", rd_data);
    end
    function_field = F_MFLO;
    #1;
    checks++;
    if (rd_data !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL mflo rd_data=%h expected ffffffeb", rd_data);
    end
    function_field = F_MULT;
    #1;
    checks++;
    if (rd_data !== 32'd0) begin
      errors++; $display("FAIL rd_other rd_data=%h expected 0", rd_data);
    end
  endtask

  task automatic test_divide;
    int e, b;
    run_op(F_DIV, 32'hFFFFFFF9, 32'd2, e, b);
    checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_signed lo=%h hi=%h expected fffffffd/ffffffff", lo, hi);
    end
    run_op(F_DIVU, 32'd100, 32'd0, e, b);
    checks++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'd100) begin
      errors++; $display("FAIL divu_zero lo=%h hi=%h expected ffffffff/00000064", lo, hi);
    end
    run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, e, b);
    checks++;
    if (lo !== 32'h80000000 || hi !== 32'd0) begin
      errors++; $display("FAIL div_overflow lo=%h hi=%h expected 80000000/00000000", lo, hi);
    end
    run_op(F_DIV, 32'hFFFFFFF9, 32'd0, e, b);
    checks++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin
      errors++; $display("FAIL div_zero lo=%h hi=%h expected ffffffff/fffffff9", lo, hi);
    end
  endtask

  task automatic test_mtlo_mthi;
    @(negedge clk);
    function_field = F_MTLO;
    operand_a = 32'h1234;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (lo !== 32'h1234 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mtlo lo=%h busy=%b done=%b expected 00001234/0/0", lo, busy, done);
    end
    function_field = F_MTHI;
    operand_a = 32'hABCD;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (hi !== 32'hABCD || lo !== 32'h1234 || busy !== 1'b0) begin
      errors++; $display("FAIL mthi hi=%h lo=%h busy=%b expected 0000abcd/00001234/0", hi, lo, busy);
    end
  endtask

  task automatic test_busy_ignore;
    int edges;
    function_field = F_DIVU;
    operand_a = 32'd9;
    operand_b = 32'd2;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    while (edges < 9) begin @(posedge clk); edges++; end
    @(negedge clk);
    function_field = F_MULTU;
    operand_a = 32'd3;
    operand_b = 32'd5;
    start = 1'b1;
    @(posedge clk);
    edges++;
    @(negedge clk);
    start = 1'b0;
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checks++;
    if (edges !== 34) begin errors++; $display("FAIL ignore_latency edges=%0d expected 34", edges); end
    checks++;
    if (lo !== 32'd4 || hi !== 32'd1) begin
      errors++; $display("FAIL ignore_result lo=%h hi=%h expected 00000004/00000001", lo, hi);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ignore_idle busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run;
    int edges, seen_done, e1, b1, e2, b2;
    function_field = F_MULT;
    operand_a = 32'd1000;
    operand_b = 32'd1000;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    while (edges < 14) begin @(posedge clk); edges++; end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
    end
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL reset_no_done pulses=%0d expected 0", seen_done); end
    run_op(F_MULTU, 32'd3, 32'd5, e1, b1);
    checks++;
    if (e1 !== 34 || lo !== 32'd15 || hi !== 32'd0) begin
      errors++; $display("FAIL post_reset_mult edges=%0d lo=%h hi=%h expected 34/0000000f/0", e1, lo, hi);
    end
    run_op(F_MULTU, 32'h00010000, 32'h00030000, e2, b2);
    checks++;
    if (e2 !== 34 || hi !== 32'd3 || lo !== 32'd0) begin
      errors++; $display("FAIL back_to_back edges=%0d hi=%h lo=%h expected 34/00000003/0", e2, hi, lo);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_divide();
    test_mtlo_mthi();
    test_busy_ignore();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
